bin2sc_v1: RTL and testbench

BIN2SC_V1 -- requirements
Module: bin2sc_v1

---
 rtl/bin2sc_pkg.sv | 15 +
 rtl/bin2sc_v1_if.sv | 25 ++
 rtl/bin2sc_v1_sng_bitrev_cmp.sv | 22 ++
 rtl/bin2sc_v1.sv | 136 +++++++++++++
 tb/tb_bin2sc_v1.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/bin2sc_pkg.sv
// Shared definitions for the bin2sc_v1 split-unipolar stochastic number generator:
// FSM state encoding and frame-length derivation.
package bin2sc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One frame covers 2^bw bit slots at two slots per cycle.
  function automatic int frame_len(input int bw);
    return 1 << (bw - 1);
  endfunction

endpackage

// File: rtl/bin2sc_v1_if.sv
// Handshake and stream bundle for bin2sc_v1: value input side plus the
// two-bit-per-cycle split-unipolar output streams.
interface bin2sc_v1_if #(
  parameter int BITWIDTH = 8
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic signed [BITWIDTH:0]   bin_in;
  logic        [1:0]          sc_pos;
  logic        [1:0]          sc_neg;
  logic                       sc_valid;
  logic                       frame_last;

  modport master (
    output in_valid, bin_in,
    input  in_ready, sc_pos, sc_neg, sc_valid, frame_last
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, sc_pos, sc_neg, sc_valid, frame_last
  );

endinterface

// File: rtl/bin2sc_v1_sng_bitrev_cmp.sv
// Stochastic bit generator for one slot: bit-reverses the slot index and
// compares it against the magnitude, giving a low-discrepancy sequence.
module sng_bitrev_cmp #(
  parameter int BITWIDTH = 8
) (
  input  logic [BITWIDTH-1:0] s,
  input  logic [BITWIDTH-1:0] m,
  output logic                bit_o
);

  logic [BITWIDTH-1:0] r;

  always_comb begin
    r = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      r[i] = s[BITWIDTH-1-i];
    end
  end

  assign bit_o = (r < m);

endmodule

// File: rtl/bin2sc_v1.sv
// Binary-to-split-unipolar stochastic converter. Optional macro BIN2SC_OUT_REG_EN
// adds one register stage on the stream outputs (sc_pos/sc_neg/sc_valid/frame_last).
module bin2sc_v1
  import bin2sc_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  bin2sc_v1_if.slave  bus
);

  localparam int            FRAME_LEN = frame_len(BITWIDTH);
  localparam int            KW        = BITWIDTH - 1;
  localparam logic [KW-1:0] K_LAST    = KW'(FRAME_LEN - 1);

  // Magnitude of a two's-complement value; the single unrepresentable case
  // (-2^BITWIDTH) clamps to the largest magnitude.
  function automatic logic [BITWIDTH-1:0] sat_mag(input logic signed [BITWIDTH:0] v);
    logic [BITWIDTH:0] a;
    a = v[BITWIDTH] ? -v : v;
    if (a[BITWIDTH]) sat_mag = '1;
    else             sat_mag = a[BITWIDTH-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [BITWIDTH-1:0] m_q, m_d;
  logic                sign_q, sign_d;

  logic                run, last, accept;
  logic [1:0]          bits, pos_c, neg_c;

  assign run          = (state_q == ST_RUN);
  assign last         = run && (k_q == K_LAST);
  assign bus.in_ready = !run || last;
  assign accept       = bus.in_valid && bus.in_ready && !clr;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    m_d     = m_q;
    sign_d  = sign_q;
    if (clr) begin
      state_d = ST_IDLE;
      k_d     = '0;
    end else if (accept) begin
      state_d = ST_RUN;
      k_d     = '0;
      m_d     = sat_mag(bus.bin_in);
      sign_d  = bus.bin_in[BITWIDTH];
    end else if (run) begin
      if (last) begin
        state_d = ST_IDLE;
        k_d     = '0;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      m_q     <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      m_q     <= m_d;
      sign_q  <= sign_d;
    end
  end

  // Stage p0: slot bits for s = 2k and s = 2k+1
  sng_bitrev_cmp #(.BITWIDTH(BITWIDTH)) u_cmp0 (
    .s     ({k_q, 1'b0}),
    .m     (m_q),
    .bit_o (bits[0])
  );

  sng_bitrev_cmp #(.BITWIDTH(BITWIDTH)) u_cmp1 (
    .s     ({k_q, 1'b1}),
    .m     (m_q),
    .bit_o (bits[1])
  );

  assign pos_c = (run && !sign_q) ? bits : 2'b00;
  assign neg_c = (run &&  sign_q) ? bits : 2'b00;

`ifdef BIN2SC_OUT_REG_EN
  // Stage p1: registered stream outputs, cleared by reset and by frame abort
  logic [1:0] sc_pos_q, sc_pos_d, sc_neg_q, sc_neg_d;
  logic       sc_valid_q, sc_valid_d, frame_last_q, frame_last_d;

  always_comb begin
    sc_pos_d     = pos_c;
    sc_neg_d     = neg_c;
    sc_valid_d   = run;
    frame_last_d = last;
    if (clr) begin
      sc_pos_d     = 2'b00;
      sc_neg_d     = 2'b00;
      sc_valid_d   = 1'b0;
      frame_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sc_pos_q     <= 2'b00;
      sc_neg_q     <= 2'b00;
      sc_valid_q   <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      sc_pos_q     <= sc_pos_d;
      sc_neg_q     <= sc_neg_d;
      sc_valid_q   <= sc_valid_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign bus.sc_pos     = sc_pos_q;
  assign bus.sc_neg     = sc_neg_q;
  assign bus.sc_valid   = sc_valid_q;
  assign bus.frame_last = frame_last_q;
`else
  assign bus.sc_pos     = pos_c;
  assign bus.sc_neg     = neg_c;
  assign bus.sc_valid   = run;
  assign bus.frame_last = last;
`endif

endmodule

// File: tb/tb_bin2sc_v1.sv
// Scoreboard bench for bin2sc_v1 (BITWIDTH=8): driver queues expected per-cycle
// stream words on accept, a negedge monitor pops and compares them.
module tb_bin2sc_v1;

  localparam int BW = 8;
  localparam int FL = 128;
`ifdef BIN2SC_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic clr;

  bin2sc_v1_if #(.BITWIDTH(BW)) bus ();

  bin2sc_v1 #(.BITWIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] pos;
    logic [1:0] neg;
    logic       last;
    int         m;
    bit         nsel;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   ones_acc = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic int ref_mag(input int v);
    int a;
    a = (v < 0) ? -v : v;
    return (a > (1 << BW) - 1) ? (1 << BW) - 1 : a;
  endfunction

  function automatic int bitrev(input int s);
    int r;
    r = 0;
    for (int i = 0; i < BW; i++) r = r * 2 + ((s >> i) & 1);
    return r;
  endfunction

  task automatic push_frame(input int v);
    exp_t x;
    int   m;
    logic [1:0] b;
    m = ref_mag(v);
    for (int k = 0; k < FL; k++) begin
      b[0] = (bitrev(2 * k)     < m);
      b[1] = (bitrev(2 * k + 1) < m);
      x.nsel = (v < 0);
      x.pos  = x.nsel ? 2'b00 : b;
      x.neg  = x.nsel ? b : 2'b00;
      x.last = (k == FL - 1);
      x.m    = m;
      q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.sc_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sc_pos", 32'(bus.sc_pos), 32'(e.pos));
          chk("sc_neg", 32'(bus.sc_neg), 32'(e.neg));
          chk("frame_last", 32'(bus.frame_last), 32'(e.last));
          ones_acc += e.nsel ? (int'(bus.sc_neg[0]) + int'(bus.sc_neg[1]))
                             : (int'(bus.sc_pos[0]) + int'(bus.sc_pos[1]));
          if (e.last) begin
            chk("ones_count", 32'(ones_acc), 32'(e.m));
            ones_acc = 0;
          end
        end
      end else begin
        chk("idle_outputs", 32'({bus.sc_pos, bus.sc_neg, bus.frame_last, bus.sc_valid}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int v, output int waited);
    logic acc;
    acc          = 1'b0;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.bin_in   = v[BW:0];
    while (!acc && waited < 1000) begin
      @(negedge clk);
      acc = bus.in_ready && !clr;
      tick();
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    else      push_frame(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, gap, v;
    reset        = 1'b1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_outputs", 32'({bus.sc_pos, bus.sc_neg, bus.frame_last, bus.sc_valid}), 32'd0);
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // +100 with first-output latency check
    offer(100, w);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk("first_valid_latency", 32'(bus.sc_valid), 32'(i == LAT));
    end
    drain();

    offer(128, w);  drain();
    offer(-256, w); drain();
    offer(0, w);    drain();

    // back-to-back: second value taken in the frame_last cycle
    offer(5, w);
    offer(-7, w2);
    chk("b2b_no_gap", 32'(w2), 32'(FL));
    drain();

    // abort at k=40 while a new value is offered
    offer(77, w);
    repeat (40) tick();
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.bin_in   = 9'sd33;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    ones_acc = 0;
    @(negedge clk);
    chk("clr_valid", 32'(bus.sc_valid), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) tick();
    @(negedge clk);
    chk("clr_not_accepted", 32'(bus.sc_valid), 32'd0);

    // abort in IDLE has priority over a simultaneous offer
    tick();
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.bin_in   = 9'sd50;
    tick();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("clr_idle_no_accept", 32'(bus.sc_valid), 32'd0);
    end

    // reset mid-frame discards the frame
    tick();
    offer(-90, w);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    ones_acc = 0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.sc_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // randomized values, mix of back-to-back and gapped frames
    repeat (24) begin
      v = int'($urandom_range(0, 511)) - 256;
      offer(v, w);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        drain();
        repeat (gap) tick();
      end
    end
    drain();
    repeat (3) tick();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
